// File: rtl/hwag_spi_tx_data_frame_pkg.sv
// Shared types and helpers for the HWAG SPI TX response path.
// Contents: command codes, STAT bit indices, frame constants, FSM state type,
// and a byte-wise CRC-8 (poly 0x07, init 0x00, no reflection, no xorout).
package hwag_spi_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned ADDR_WIDTH  = 8;
  localparam int unsigned FRAME_BYTES = 7;

  localparam logic [7:0] CMD_NOP   = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  localparam int unsigned STAT_RD_VALID = 0;
  localparam int unsigned STAT_CRC_ERR  = 1;
  localparam int unsigned STAT_BUSY     = 2;
  localparam int unsigned STAT_UNK_CMD  = 3;
  localparam int unsigned STAT_TIMEOUT  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2,
    SEND  = 2'd3
  } tx_state_t;

  // One byte of CRC-8, MSB first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/hwag_spi_tx_data_frame_if.sv
// Register-bank read handshake (level request, pulsed acknowledge).
// master: requester (rd_req, rd_addr out; rd_data, rd_valid in)
// slave : register bank
interface hwag_spi_tx_data_frame_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) ();
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport master (output rd_req, output rd_addr, input rd_data, input rd_valid);
  modport slave  (input rd_req, input rd_addr, output rd_data, output rd_valid);
endinterface

// File: rtl/hwag_spi_tx_data_frame_crc8.sv
// Byte-serial CRC-8 over the six payload bytes of a response frame.
// Ports: start clears the CRC and drops done; each byte_valid folds byte_in;
// done rises once FRAME_BYTES-1 bytes are folded. Reset state is the CRC of an
// all-zero frame (0x00), so done is high out of reset.
module hwag_spi_tx_crc8
  import hwag_spi_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [7:0] crc_out,
  output logic       done
);
  localparam int unsigned CNT_W = 3;

  logic [7:0]       crc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      crc_q  <= 8'h00;
      cnt_q  <= '0;
      done_q <= 1'b1;
    end else if (start) begin
      crc_q  <= 8'h00;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (byte_valid && !done_q) begin
      crc_q <= crc8_byte(crc_q, byte_in);
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(FRAME_BYTES - 2)) done_q <= 1'b1;
    end
  end

  assign crc_out = crc_q;
  assign done    = done_q;
endmodule

// File: rtl/hwag_spi_tx_data_frame.sv
// Transmit side of the HWAG SPI register protocol.
// Answers the command of frame N in frame N+1 as [STAT][ADDR][DATA32][CRC8].
// Ports: clk, nrst (async, active low); spi_ss (synchronised, active low);
//   rx_frame_done/rx_crc_ok/rx_cmd/rx_addr from the RX side; tx_next strobe
//   and tx_byte to spi_slave; busy (FETCH); rd_bus register-bank read master.
// Build option: HWAG_SPI_TX_SEQ_EN adds a 3-bit frame counter in STAT[7:5].
module hwag_spi_tx_data_frame
  import hwag_spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             spi_ss,
  input  logic                             rx_frame_done,
  input  logic                             rx_crc_ok,
  input  logic [7:0]                       rx_cmd,
  input  logic [7:0]                       rx_addr,
  input  logic                             tx_next,
  output logic [7:0]                       tx_byte,
  output logic                             busy,
  hwag_spi_tx_data_frame_if.master         rd_bus
);
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned TMO_W  = 8;
  localparam int unsigned FLAG_W = 5;
  localparam int unsigned SEQ_W  = 3;

  tx_state_t             state_q, state_d;
  logic [FLAG_W-1:0]     flags_q, flags_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  pend_q, pend_d;
  logic                  rd_req_q, rd_req_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic                  busy_q, busy_d;
  logic                  ss_q;
  logic                  feeding_q;
  logic [IDX_W-1:0]      feed_q;
  logic                  crc_start_c;
  logic [7:0]            crc_c;
  logic                  crc_done_c;
  logic [SEQ_W-1:0]      seq_q, seq_nxt;

  wire ss_fall = ss_q & ~spi_ss;
  wire ss_rise = ~ss_q & spi_ss;

  // Byte n of the response frame; index 7 is the filler.
  function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx, input logic [7:0] stat,
                                            input logic [7:0] addr, input logic [31:0] data,
                                            input logic [7:0] crc);
    case (idx)
      3'd0:    return stat;
      3'd1:    return addr;
      3'd2:    return data[31:24];
      3'd3:    return data[23:16];
      3'd4:    return data[15:8];
      3'd5:    return data[7:0];
      3'd6:    return crc;
      default: return 8'hFF;
    endcase
  endfunction

`ifdef HWAG_SPI_TX_SEQ_EN
  // Frame counter, advanced on every ss rise that ends a SEND.
  wire seq_inc = (state_q == SEND) && ss_rise;
  assign seq_nxt = seq_q + SEQ_W'(seq_inc);
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) seq_q <= '0;
    else       seq_q <= seq_nxt;
  end
`else
  assign seq_q   = '0;
  assign seq_nxt = '0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    addr_d      = addr_q;
    data_d      = data_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    pend_d      = pend_q;
    rd_req_d    = rd_req_q;
    rd_addr_d   = rd_addr_q;
    crc_start_c = 1'b0;

    if (rx_frame_done) begin
      // New command wins over whatever the current state is doing.
      addr_d   = ADDR_WIDTH'(rx_addr);
      flags_d  = '0;
      data_d   = '0;
      pend_d   = 1'b0;
      rd_req_d = 1'b0;
      state_d  = READY;
      if (!rx_crc_ok) begin
        flags_d[STAT_CRC_ERR] = 1'b1;
      end else begin
        case (rx_cmd)
          CMD_READ: begin
            rd_addr_d = ADDR_WIDTH'(rx_addr);
            rd_req_d  = 1'b1;
            tmo_d     = '0;
            state_d   = FETCH;
          end
          CMD_WRITE, CMD_NOP: ;
          default: flags_d[STAT_UNK_CMD] = 1'b1;
        endcase
      end
      crc_start_c = (state_d == READY);
    end else begin
      case (state_q)
        IDLE, READY: begin
          // A frame start waits here until the CRC is final.
          if (pend_q || ss_fall) begin
            if (crc_done_c) begin
              state_d = SEND;
              idx_d   = '0;
              pend_d  = 1'b0;
            end else begin
              pend_d = 1'b1;
            end
          end
        end
        FETCH: begin
          if (ss_fall) begin
            rd_req_d           = 1'b0;
            flags_d[STAT_BUSY] = 1'b1;
            data_d             = '0;
            pend_d             = 1'b1;
            state_d            = READY;
            crc_start_c        = 1'b1;
          end else if (rd_bus.rd_valid) begin
            data_d                 = rd_bus.rd_data;
            flags_d[STAT_RD_VALID] = 1'b1;
            rd_req_d               = 1'b0;
            state_d                = READY;
            crc_start_c            = 1'b1;
          end else if (tmo_q == TMO_W'(FETCH_TIMEOUT - 1)) begin
            flags_d[STAT_TIMEOUT] = 1'b1;
            data_d                = '0;
            rd_req_d              = 1'b0;
            state_d               = READY;
            crc_start_c           = 1'b1;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        SEND: begin
          if (ss_rise) begin
            state_d     = IDLE;
            flags_d     = '0;
            crc_start_c = 1'b1;
          end else if (tx_next && (idx_q != 3'd7)) begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == FETCH);
    // Outside SEND the STAT byte is preloaded for spi_slave.
    if (state_d == SEND)
      tx_byte_d = frame_byte(idx_d, {seq_q, flags_q}, 8'(addr_q), 32'(data_q), crc_c);
    else
      tx_byte_d = {seq_nxt, flags_d};
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      flags_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      idx_q     <= '0;
      tmo_q     <= '0;
      pend_q    <= 1'b0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      tx_byte_q <= 8'h00;
      busy_q    <= 1'b0;
      ss_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      pend_q    <= pend_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      tx_byte_q <= tx_byte_d;
      busy_q    <= busy_d;
      ss_q      <= spi_ss;
    end
  end

  // Feeds payload bytes 0..5 to the CRC on the cycles after a start.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      feeding_q <= 1'b0;
      feed_q    <= '0;
    end else if (crc_start_c) begin
      feeding_q <= 1'b1;
      feed_q    <= '0;
    end else if (feeding_q) begin
      feed_q <= feed_q + IDX_W'(1);
      if (feed_q == IDX_W'(FRAME_BYTES - 2)) feeding_q <= 1'b0;
    end
  end

  hwag_spi_tx_crc8 u_crc8 (
    .clk        (clk),
    .nrst       (nrst),
    .start      (crc_start_c),
    .byte_in    (frame_byte(feed_q, {seq_q, flags_q}, 8'(addr_q), 32'(data_q), 8'h00)),
    .byte_valid (feeding_q),
    .crc_out    (crc_c),
    .done       (crc_done_c)
  );

  assign tx_byte        = tx_byte_q;
  assign busy           = busy_q;
  assign rd_bus.rd_req  = rd_req_q;
  assign rd_bus.rd_addr = rd_addr_q;
endmodule
